multi_cycle_ctrl: RTL and testbench

- Main control FSM for the multi-cycle MIPS CPU.
- Steps each instruction through fetch, decode, execute, memory and write-back states.
- Drives the mux selects, write enables and memory strobes of the shared datapath (one ALU, one memory).
- Issues the 3-bit ALU operation class to the downstream ALU-control decoder, which combines it with funct.

---
 rtl/multi_cycle_ctrl_pkg.sv | 84 ++++++++
 rtl/multi_cycle_ctrl_if.sv | 32 +++
 rtl/multi_cycle_ctrl_opdecode.sv | 30 +++
 rtl/multi_cycle_ctrl.sv | 112 +++++++++++
 tb/tb_multi_cycle_ctrl.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: opcodes, state and aluop
// encodings, the instruction-class decode type and the Moore output bundle.
package multi_cycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_IMM_EXEC = 4'd10,
    S_IMM_WB   = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_RTYPE = 3'b010,
    ALU_AND   = 3'b011,
    ALU_OR    = 3'b100,
    ALU_SLT   = 3'b101
  } aluop_t;

  typedef enum logic [2:0] {
    CLS_NONE, CLS_RTYPE, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE, CLS_JUMP, CLS_IMM
  } iclass_t;

  typedef struct packed {
    logic       pc_we;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_we;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] aluop;
    logic [1:0] pc_src;
    logic       done;
    logic       halted;
  } moore_t;

  // State-only part of the outputs; mem_ready and branch gating are added by the caller.
  function automatic moore_t moore_of(state_t s, aluop_t imm_op);
    moore_t m;
    m = '0;
    case (s)
      S_FETCH:    begin m.mem_rd = 1'b1; m.alu_src_b = 2'b01; m.aluop = ALU_ADD; end
      S_DECODE:   begin m.alu_src_b = 2'b11; m.aluop = ALU_ADD; end
      S_MEM_ADDR: begin m.alu_src_a = 1'b1; m.alu_src_b = 2'b10; m.aluop = ALU_ADD; end
      S_MEM_RD:   begin m.mem_rd = 1'b1; m.iord = 1'b1; end
      S_MEM_WB:   begin m.reg_we = 1'b1; m.mem_to_reg = 1'b1; m.done = 1'b1; end
      S_MEM_WR:   begin m.mem_wr = 1'b1; m.iord = 1'b1; end
      S_EXEC:     begin m.alu_src_a = 1'b1; m.aluop = ALU_RTYPE; end
      S_R_WB:     begin m.reg_we = 1'b1; m.reg_dst = 1'b1; m.done = 1'b1; end
      S_BRANCH:   begin m.alu_src_a = 1'b1; m.aluop = ALU_SUB; m.pc_src = 2'b01; m.done = 1'b1; end
      S_JUMP:     begin m.pc_src = 2'b10; m.pc_we = 1'b1; m.done = 1'b1; end
      S_IMM_EXEC: begin m.alu_src_a = 1'b1; m.alu_src_b = 2'b10; m.aluop = imm_op; end
      S_IMM_WB:   begin m.reg_we = 1'b1; m.done = 1'b1; end
      S_HALT:     m.halted = 1'b1;
      default:    m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Control/status bundle between the multi-cycle control FSM (master) and the datapath (slave).
interface multi_cycle_ctrl_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_we;
  logic       iord;
  logic       mem_rd;
  logic       mem_wr;
  logic       ir_we;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_we;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] aluop;
  logic [1:0] pc_src;
  logic       instr_done;
  logic       halted;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_we, iord, mem_rd, mem_wr, ir_we, mem_to_reg, reg_dst, reg_we,
           alu_src_a, alu_src_b, aluop, pc_src, instr_done, halted
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_we, iord, mem_rd, mem_wr, ir_we, mem_to_reg, reg_dst, reg_we,
           alu_src_a, alu_src_b, aluop, pc_src, instr_done, halted
  );
endinterface

// File: rtl/multi_cycle_ctrl_opdecode.sv
// Combinational opcode -> instruction class decode, with the I-type ALU op and an illegal flag.
module multi_cycle_ctrl_opdecode
  import multi_cycle_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output iclass_t    iclass,
  output aluop_t     imm_aluop,
  output logic       illegal
);

  always_comb begin
    iclass    = CLS_NONE;
    imm_aluop = ALU_ADD;
    illegal   = 1'b0;
    case (opcode)
      OP_RTYPE: iclass = CLS_RTYPE;
      OP_LW:    iclass = CLS_LW;
      OP_SW:    iclass = CLS_SW;
      OP_BEQ:   iclass = CLS_BEQ;
      OP_BNE:   iclass = CLS_BNE;
      OP_J:     iclass = CLS_JUMP;
      OP_ADDI:  begin iclass = CLS_IMM; imm_aluop = ALU_ADD; end
      OP_ANDI:  begin iclass = CLS_IMM; imm_aluop = ALU_AND; end
      OP_ORI:   begin iclass = CLS_IMM; imm_aluop = ALU_OR;  end
      OP_SLTI:  begin iclass = CLS_IMM; imm_aluop = ALU_SLT; end
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS CPU (fetch/decode/execute/memory/write-back).
// Optional perf counters cycle_cnt/instr_cnt under `define MULTI_CYCLE_CTRL_PERF_EN.
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b1
`ifdef MULTI_CYCLE_CTRL_PERF_EN
  ,
  parameter int PERF_W = 32
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  multi_cycle_ctrl_if.master bus
`ifdef MULTI_CYCLE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0]  cycle_cnt,
  output logic [PERF_W-1:0]  instr_cnt
`endif
);

  iclass_t iclass;
  aluop_t  imm_aluop;
  logic    illegal;

  multi_cycle_ctrl_opdecode u_opdecode (
    .opcode    (bus.opcode),
    .iclass    (iclass),
    .imm_aluop (imm_aluop),
    .illegal   (illegal)
  );

  state_t state;
  state_t nxt;
  logic   run;
  moore_t mo;

  always_comb begin
    nxt = state;
    case (state)
      S_FETCH:    if (bus.mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        case (iclass)
          CLS_LW, CLS_SW:   nxt = S_MEM_ADDR;
          CLS_RTYPE:        nxt = S_EXEC;
          CLS_BEQ, CLS_BNE: nxt = S_BRANCH;
          CLS_JUMP:         nxt = S_JUMP;
          CLS_IMM:          nxt = S_IMM_EXEC;
          default:          nxt = ILLEGAL_HALT ? S_HALT : S_FETCH;
        endcase
      end
      S_MEM_ADDR: nxt = (iclass == CLS_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (bus.mem_ready) nxt = S_MEM_WB;
      S_MEM_WR:   if (bus.mem_ready) nxt = S_FETCH;
      S_EXEC:     nxt = S_R_WB;
      S_IMM_EXEC: nxt = S_IMM_WB;
      S_HALT:     nxt = S_HALT;
      default:    nxt = S_FETCH;
    endcase
  end

  // run stays low until the first edge after reset release, so that edge starts the fetch
  // instead of consuming it; the Moore bundle is registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      run   <= 1'b0;
      mo    <= '0;
    end else begin
      run <= 1'b1;
      if (run) state <= nxt;
      mo <= moore_of(run ? nxt : S_FETCH, imm_aluop);
    end
  end

  logic in_fetch, in_decode, in_memwr, in_branch, br_take;

  assign in_fetch  = run && (state == S_FETCH);
  assign in_decode = run && (state == S_DECODE);
  assign in_memwr  = run && (state == S_MEM_WR);
  assign in_branch = run && (state == S_BRANCH);
  assign br_take   = (iclass == CLS_BNE) ? !bus.zero : bus.zero;

  assign bus.ir_we      = in_fetch && bus.mem_ready;
  assign bus.pc_we      = mo.pc_we || (in_fetch && bus.mem_ready) || (in_branch && br_take);
  assign bus.instr_done = mo.done || (in_memwr && bus.mem_ready)
                          || (in_decode && illegal && !ILLEGAL_HALT);
  assign bus.iord       = mo.iord;
  assign bus.mem_rd     = mo.mem_rd;
  assign bus.mem_wr     = mo.mem_wr;
  assign bus.mem_to_reg = mo.mem_to_reg;
  assign bus.reg_dst    = mo.reg_dst;
  assign bus.reg_we     = mo.reg_we;
  assign bus.alu_src_a  = mo.alu_src_a;
  assign bus.alu_src_b  = mo.alu_src_b;
  assign bus.aluop      = mo.aluop;
  assign bus.pc_src     = mo.pc_src;
  assign bus.halted     = mo.halted;

`ifdef MULTI_CYCLE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (!bus.halted)     cycle_cnt <= cycle_cnt + PERF_W'(1);
      if (bus.instr_done)  instr_cnt <= instr_cnt + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Randomized bench for multi_cycle_ctrl: per-instruction step lists drive a reference model.
module tb_multi_cycle_ctrl;

  typedef enum int {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_ADDR, ST_LOAD, ST_LOADWB, ST_STORE,
    ST_ALU, ST_ALUWB, ST_BR, ST_JMP, ST_IALU, ST_IWB, ST_HALT
  } step_e;

  logic clk = 1'b0;
  logic rst_n;
  multi_cycle_ctrl_if bus();

  multi_cycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  step_e       seq[$];
  logic [5:0]  op_plan[$];
  logic [5:0]  cur_op = 6'b000000;
  int          load_waits = 0;
  logic [17:0] exp_vec = '0;
  step_e       exp_step = ST_IDLE;
  bit          chk_en = 1'b0;
  logic [5:0]  legal_ops [10] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                                  6'b000010, 6'b001000, 6'b001100, 6'b001101, 6'b001010};

  // {pc_we, iord, mem_rd, mem_wr, ir_we, mem_to_reg, reg_dst, reg_we, alu_src_a,
  //  alu_src_b[1:0], aluop[2:0], pc_src[1:0], instr_done, halted}
  function automatic logic [17:0] act_vec();
    return {bus.pc_we, bus.iord, bus.mem_rd, bus.mem_wr, bus.ir_we, bus.mem_to_reg,
            bus.reg_dst, bus.reg_we, bus.alu_src_a, bus.alu_src_b, bus.aluop,
            bus.pc_src, bus.instr_done, bus.halted};
  endfunction

  function automatic logic [17:0] expv(step_e s, logic [5:0] op, logic mr, logic z);
    logic pc_we = 0, iord = 0, rd = 0, wr = 0, irwe = 0, m2r = 0, rdst = 0, rwe = 0;
    logic asa = 0, done = 0, hlt = 0;
    logic [1:0] asb = 2'b00, pcs = 2'b00;
    logic [2:0] alu = 3'b000;
    case (s)
      ST_FETCH:  begin rd = 1; asb = 2'b01; pc_we = mr; irwe = mr; end
      ST_DECODE: asb = 2'b11;
      ST_ADDR:   begin asa = 1; asb = 2'b10; end
      ST_LOAD:   begin rd = 1; iord = 1; end
      ST_LOADWB: begin rwe = 1; m2r = 1; done = 1; end
      ST_STORE:  begin wr = 1; iord = 1; done = mr; end
      ST_ALU:    begin asa = 1; alu = 3'b010; end
      ST_ALUWB:  begin rwe = 1; rdst = 1; done = 1; end
      ST_BR:     begin asa = 1; alu = 3'b001; pcs = 2'b01; done = 1;
                       pc_we = (op == 6'b000101) ? !z : z; end
      ST_JMP:    begin pcs = 2'b10; pc_we = 1; done = 1; end
      ST_IALU: begin
        asa = 1; asb = 2'b10;
        alu = (op == 6'b001100) ? 3'b011 : (op == 6'b001101) ? 3'b100 :
              (op == 6'b001010) ? 3'b101 : 3'b000;
      end
      ST_IWB:    begin rwe = 1; done = 1; end
      ST_HALT:   hlt = 1;
      default:   ;
    endcase
    return {pc_we, iord, rd, wr, irwe, m2r, rdst, rwe, asa, asb, alu, pcs, done, hlt};
  endfunction

  task automatic check(string name, logic [17:0] act, logic [17:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Steps an instruction takes after its fetch, by opcode.
  task automatic push_tail(logic [5:0] op);
    seq.push_back(ST_DECODE);
    case (op)
      6'b000000:            begin seq.push_back(ST_ALU); seq.push_back(ST_ALUWB); end
      6'b100011:            begin seq.push_back(ST_ADDR); seq.push_back(ST_LOAD);
                                  seq.push_back(ST_LOADWB); end
      6'b101011:            begin seq.push_back(ST_ADDR); seq.push_back(ST_STORE); end
      6'b000100, 6'b000101: seq.push_back(ST_BR);
      6'b000010:            seq.push_back(ST_JMP);
      6'b001000, 6'b001100, 6'b001101, 6'b001010:
                            begin seq.push_back(ST_IALU); seq.push_back(ST_IWB); end
      default:              seq.push_back(ST_HALT);
    endcase
  endtask

  always @(negedge clk)
    if (chk_en) check($sformatf("step_%s", exp_step.name()), act_vec(), exp_vec);

  task automatic do_reset(int hold);
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_reset_drop", act_vec(), 18'd0);
    bus.mem_ready = 1'b1;
    bus.zero = 1'b0;
    exp_vec = '0;
    exp_step = ST_IDLE;
    chk_en = 1'b1;
    repeat (hold) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(posedge clk); #1;
    seq.delete();
    seq.push_back(ST_FETCH);
  endtask

  task automatic run_cycles(int n, bit mr_always, bit z_force);
    for (int c = 0; c < n; c++) begin
      if (seq[0] == ST_LOAD && load_waits > 0) begin
        bus.mem_ready = 1'b0;
        load_waits--;
      end else begin
        bus.mem_ready = mr_always ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
      bus.zero = z_force ? 1'b1 : 1'($urandom_range(0, 1));
      bus.opcode = cur_op;
      exp_vec = expv(seq[0], cur_op, bus.mem_ready, bus.zero);
      exp_step = seq[0];
      chk_en = 1'b1;
      @(posedge clk); #1;
      if (!(seq[0] inside {ST_FETCH, ST_LOAD, ST_STORE}) || bus.mem_ready) begin
        if (seq[0] == ST_FETCH) begin
          cur_op = (op_plan.size() > 0) ? op_plan.pop_front() : legal_ops[$urandom_range(0, 9)];
          void'(seq.pop_front());
          push_tail(cur_op);
        end else if (seq[0] != ST_HALT) begin
          void'(seq.pop_front());
          if (seq.size() == 0) seq.push_back(ST_FETCH);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.opcode = 6'b000000;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;

    check("pin_fetch",  expv(ST_FETCH, 6'd0, 1'b1, 1'b0),        18'b1_0_1_0_1_0_0_0_0_01_000_00_0_0);
    check("pin_exec",   expv(ST_ALU, 6'd0, 1'b1, 1'b0),          18'b0_0_0_0_0_0_0_0_1_00_010_00_0_0);
    check("pin_beq_z",  expv(ST_BR, 6'b000100, 1'b1, 1'b1),      18'b1_0_0_0_0_0_0_0_1_00_001_01_1_0);
    check("pin_bne_z",  expv(ST_BR, 6'b000101, 1'b1, 1'b1),      18'b0_0_0_0_0_0_0_0_1_00_001_01_1_0);
    check("pin_ori",    expv(ST_IALU, 6'b001101, 1'b1, 1'b0),    18'b0_0_0_0_0_0_0_0_1_10_100_00_0_0);
    check("pin_lw_wb",  expv(ST_LOADWB, 6'b100011, 1'b1, 1'b0),  18'b0_0_0_0_0_1_0_1_0_00_000_00_1_0);
    check("pin_halt",   expv(ST_HALT, 6'b111111, 1'b0, 1'b0),    18'd1);

    // Power-on reset, then one of each instruction with memory always ready and zero=1.
    do_reset(3);
    op_plan = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                6'b000010, 6'b001101, 6'b001000, 6'b001100, 6'b001010};
    load_waits = 2;
    run_cycles(44, 1'b1, 1'b1);

    run_cycles(600, 1'b0, 1'b0);

    // Reset lands mid-instruction.
    do_reset(2);
    run_cycles(300, 1'b0, 1'b0);

    // Illegal opcode parks the FSM in HALT until reset.
    op_plan.push_back(6'b111111);
    run_cycles(25, 1'b1, 1'b0);
    check("halted_literal", {17'd0, bus.halted}, 18'd1);
    do_reset(1);
    run_cycles(60, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
